// File: rtl/imem_loader_if.sv
// Byte-stream input plus port-2 write bus between the program loader and the imem arbiter.
// The master side is the loader; the slave side is the stream source and arbiter.
interface imem_loader_if #(
    parameter int PORTW     = 32,
    parameter int ADDRWIDTH = 7
);
    logic [7:0]           byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic [PORTW-1:0]     d_2;
    logic [ADDRWIDTH-1:0] addr_2;
    logic                 en_2_x;
    logic                 wr_2_x;
    logic [PORTW-1:0]     bit_wr_2_x;
    logic                 mem_busy;

    modport master (
        input  byte_in, byte_valid, mem_busy,
        output byte_ready, d_2, addr_2, en_2_x, wr_2_x, bit_wr_2_x
    );

    modport slave (
        output byte_in, byte_valid, mem_busy,
        input  byte_ready, d_2, addr_2, en_2_x, wr_2_x, bit_wr_2_x
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: packs a little-endian byte stream into imem words and writes them from
// address 0 through the arbiter's secondary port, holding the core in reset until done.
module imem_loader #(
    parameter int PORTW     = 32,
    parameter int ADDRWIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rstx,
    input  logic                 start,
    input  logic [ADDRWIDTH:0]   load_len,
    imem_loader_if.master        bus,
    output logic                 core_rstx,
    output logic                 done
);
    localparam int BYTES = PORTW / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]     LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [ADDRWIDTH:0] DEPTH     = {1'b1, {ADDRWIDTH{1'b0}}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]           r_state;
    logic [ADDRWIDTH:0]   r_len;
    logic [ADDRWIDTH:0]   r_word_cnt;
    logic [BCW-1:0]       r_byte_cnt;
    logic [PORTW-1:0]     r_d;
    logic [ADDRWIDTH-1:0] r_addr;
    logic                 r_en_x;
    logic                 r_wr_x;
    logic [PORTW-1:0]     r_bit_wr_x;
    logic                 r_core_rstx;
    logic                 r_done;

    logic                 w_accept;
    logic [ADDRWIDTH:0]   w_len_clamped;
    logic [ADDRWIDTH:0]   w_word_cnt_inc;
    logic [PORTW-1:0]     w_d_next;

    assign bus.byte_ready = (r_state == S_COLLECT);
    assign w_accept       = bus.byte_valid && (r_state == S_COLLECT);
    // Clamping to the depth is what keeps addr_2 from ever wrapping.
    assign w_len_clamped  = (load_len > DEPTH) ? DEPTH : load_len;
    assign w_word_cnt_inc = r_word_cnt + 1'b1;

    // Byte k of the word lands in lane k: only the lane selected by the byte counter updates.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign w_d_next[8*gi +: 8] = (r_byte_cnt == BCW'(gi)) ? bus.byte_in : r_d[8*gi +: 8];
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_d         <= '0;
            r_addr      <= '0;
            r_en_x      <= 1'b1;
            r_wr_x      <= 1'b1;
            r_bit_wr_x  <= '1;
            r_core_rstx <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_len      <= w_len_clamped;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                        r_addr     <= '0;
                        if (w_len_clamped == '0) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_core_rstx <= 1'b1;
                        end else begin
                            r_state     <= S_COLLECT;
                            r_done      <= 1'b0;
                            r_core_rstx <= 1'b0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_d <= w_d_next;
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            r_state    <= S_WRITE;
                            r_en_x     <= 1'b0;
                            r_wr_x     <= 1'b0;
                            r_bit_wr_x <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // A busy arbiter leaves every output untouched so the same write repeats.
                    if (!bus.mem_busy) begin
                        r_en_x     <= 1'b1;
                        r_wr_x     <= 1'b1;
                        r_bit_wr_x <= '1;
                        r_word_cnt <= w_word_cnt_inc;
                        if (w_word_cnt_inc == r_len) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_core_rstx <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_COLLECT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.d_2        = r_d;
    assign bus.addr_2     = r_addr;
    assign bus.en_2_x     = r_en_x;
    assign bus.wr_2_x     = r_wr_x;
    assign bus.bit_wr_2_x = r_bit_wr_x;
    assign core_rstx      = r_core_rstx;
    assign done           = r_done;
endmodule
